axi4l_master: RTL and testbench

AXI4-Lite initiator that converts the core's single-beat load/store requests into AXI4-Lite read or write transactions. It is the counterpart of the AXI4-Lite slaves on the memory bus, such as the instruction RAM and the peripherals. The block sits between the core's memory-access stage and the bus interconnect. It handles one outstanding transaction at a time, and reports completion with a one-cycle done pulse carrying read data and an error flag.

---
 rtl/axi4l_master.sv | 203 ++++++++++++++++++++
 tb/tb_axi4l_master.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi4l_master.sv
// axi4l_master: AXI4-Lite initiator for single-beat core loads/stores.
// One outstanding transaction; completion reported with a one-cycle done
// pulse carrying read data and an error flag.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   mem_req_i/we_i        request strobe and direction (1 = write)
//   mem_addr_i            byte address
//   mem_wdata_i/wstrb_i   write data and byte strobes
//   mem_ready_o           idle, a request is accepted this cycle
//   mem_done_o            one-cycle completion pulse
//   mem_rdata_o           read data, held until the next done
//   mem_err_o             non-OKAY response, held until the next done
//   m_axi_*               AXI4-Lite master channels AW, W, B, AR, R
module axi4l_master #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mem_req_i,
  input  logic                mem_we_i,
  input  logic [ADDR_W-1:0]   mem_addr_i,
  input  logic [DATA_W-1:0]   mem_wdata_i,
  input  logic [DATA_W/8-1:0] mem_wstrb_i,
  output logic                mem_ready_o,
  output logic                mem_done_o,
  output logic [DATA_W-1:0]   mem_rdata_o,
  output logic                mem_err_o,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic [2:0]          m_axi_awprot,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic [2:0]          m_axi_arprot,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic [1:0]          m_axi_rresp,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready
);

  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WADDR,
    S_WRESP,
    S_RADDR,
    S_RDATA
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                arvalid_q, arvalid_d;
  logic                bready_q, bready_d;
  logic                rready_q, rready_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic aw_ok, w_ok;

  assign aw_hs = awvalid_q & m_axi_awready;
  assign w_hs  = wvalid_q  & m_axi_wready;
  assign ar_hs = arvalid_q & m_axi_arready;
  assign b_hs  = bready_q  & m_axi_bvalid;
  assign r_hs  = rready_q  & m_axi_rvalid;

  // A write channel is finished once its valid has dropped or it handshakes now.
  assign aw_ok = ~awvalid_q | aw_hs;
  assign w_ok  = ~wvalid_q  | w_hs;

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    bready_d  = bready_q;
    rready_d  = rready_q;
    done_d    = 1'b0;
    err_d     = err_q;
    rdata_d   = rdata_q;

    case (state_q)
      S_IDLE: begin
        if (mem_req_i) begin
          addr_d  = mem_addr_i;
          wdata_d = mem_wdata_i;
          wstrb_d = mem_wstrb_i;
          if (mem_we_i) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = S_WADDR;
          end else begin
            arvalid_d = 1'b1;
            state_d   = S_RADDR;
          end
        end
      end
      S_WADDR: begin
        awvalid_d = awvalid_q & ~aw_hs;
        wvalid_d  = wvalid_q & ~w_hs;
        if (aw_ok && w_ok) begin
          bready_d = 1'b1;
          state_d  = S_WRESP;
        end
      end
      S_WRESP: begin
        if (b_hs) begin
          bready_d = 1'b0;
          done_d   = 1'b1;
          err_d    = |m_axi_bresp;
          state_d  = S_IDLE;
        end
      end
      S_RADDR: begin
        if (ar_hs) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RDATA;
        end
      end
      S_RDATA: begin
        if (r_hs) begin
          rready_d = 1'b0;
          done_d   = 1'b1;
          err_d    = |m_axi_rresp;
          rdata_d  = m_axi_rdata;
          state_d  = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      rready_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      bready_q  <= bready_d;
      rready_q  <= rready_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  assign mem_ready_o   = (state_q == S_IDLE);
  assign mem_done_o    = done_q;
  assign mem_rdata_o   = rdata_q;
  assign mem_err_o     = err_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axi4l_master.sv
// tb_axi4l_master: self-checking bench for axi4l_master. Each transaction
// is described by its handshake delays; the expected per-cycle bus and
// completion behaviour is derived from those delays.
module tb_axi4l_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req_i, mem_we_i;
  logic [31:0] mem_addr_i, mem_wdata_i;
  logic [3:0]  mem_wstrb_i;
  logic        mem_ready_o, mem_done_o, mem_err_o;
  logic [31:0] mem_rdata_o;
  logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
  logic [2:0]  m_axi_awprot, m_axi_arprot;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [1:0]  m_axi_bresp, m_axi_rresp;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic        m_axi_rvalid, m_axi_rready;

  axi4l_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
    .mem_wdata_i(mem_wdata_i), .mem_wstrb_i(mem_wstrb_i),
    .mem_ready_o(mem_ready_o), .mem_done_o(mem_done_o),
    .mem_rdata_o(mem_rdata_o), .mem_err_o(mem_err_o),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [31:0] exp_rdata = '0;
  logic        exp_err   = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic bit rnd();
    return bit'($urandom_range(0, 1));
  endfunction

  // Core-side inputs are don't-care garbage once a request has been accepted.
  task automatic junk_core(input bit req);
    mem_req_i   = req;
    mem_we_i    = rnd();
    mem_addr_i  = $urandom;
    mem_wdata_i = $urandom;
    mem_wstrb_i = 4'($urandom_range(0, 15));
  endtask

  // Idle cycles with stray response valids the master must ignore.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      mem_req_i = 1'b0;
      @(posedge clk);
      @(negedge clk);
      junk_core(1'b0);
      m_axi_awready = rnd(); m_axi_wready = rnd(); m_axi_arready = rnd();
      m_axi_bvalid = rnd(); m_axi_rvalid = rnd();
      m_axi_bresp = 2'($urandom_range(0, 3)); m_axi_rresp = 2'($urandom_range(0, 3));
      m_axi_rdata = $urandom;
      check("idle_done",   64'(mem_done_o), 64'(0));
      check("idle_ready",  64'(mem_ready_o), 64'(1));
      check("idle_valids", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready}), 64'(0));
      check("idle_rdata",  64'(mem_rdata_o), 64'(exp_rdata));
      check("idle_err",    64'(mem_err_o), 64'(exp_err));
    end
  endtask

  // One transaction. da: AW/AR delay, dw: W delay, dl: B/R delay after the
  // address phase completes. Called at a negedge where the master is idle;
  // returns at the negedge of the done cycle.
  task automatic run_txn(input bit we, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input int da, input int dw, input int dl,
                         input logic [1:0] resp, input logic [31:0] rd);
    int m, hs, d;
    m  = we ? ((da > dw) ? da : dw) : da;
    hs = 2 + m + dl;
    d  = hs + 1;
    for (int k = 0; k <= d; k++) begin
      if (k > 0) begin
        @(posedge clk);
        @(negedge clk);
        junk_core((k < d) ? rnd() : 1'b0);
      end else begin
        mem_req_i = 1'b1; mem_we_i = we; mem_addr_i = addr;
        mem_wdata_i = data; mem_wstrb_i = strb;
      end
      m_axi_awready = (k == 1 + da) || (k > 1 + da && rnd());
      m_axi_wready  = (k == 1 + dw) || (k > 1 + dw && rnd());
      m_axi_arready = (k == 1 + da) || (k > 1 + da && rnd());
      if (we) begin
        m_axi_bvalid = (k == hs) || (k < 2 + m && rnd());
        m_axi_rvalid = rnd();
      end else begin
        m_axi_rvalid = (k == hs) || (k < 2 + m && rnd());
        m_axi_bvalid = rnd();
      end
      m_axi_bresp = (k == hs) ? resp : 2'($urandom_range(0, 3));
      m_axi_rresp = (k == hs) ? resp : 2'($urandom_range(0, 3));
      m_axi_rdata = (k == hs) ? rd : $urandom;

      if (k == 0) begin
        check("accept_ready", 64'(mem_ready_o), 64'(1));
      end else begin
        check("awvalid", 64'(m_axi_awvalid), 64'(we && k <= 1 + da));
        check("wvalid",  64'(m_axi_wvalid),  64'(we && k <= 1 + dw));
        check("arvalid", 64'(m_axi_arvalid), 64'(!we && k <= 1 + da));
        check("bready",  64'(m_axi_bready),  64'(we && k >= 2 + m && k <= hs));
        check("rready",  64'(m_axi_rready),  64'(!we && k >= 2 + m && k <= hs));
        if (we && k <= 1 + da) begin
          check("awaddr", 64'(m_axi_awaddr), 64'(addr));
          check("awprot", 64'(m_axi_awprot), 64'(0));
        end
        if (we && k <= 1 + dw) begin
          check("wdata", 64'(m_axi_wdata), 64'(data));
          check("wstrb", 64'(m_axi_wstrb), 64'(strb));
        end
        if (!we && k <= 1 + da) begin
          check("araddr", 64'(m_axi_araddr), 64'(addr));
          check("arprot", 64'(m_axi_arprot), 64'(0));
        end
        check("done",  64'(mem_done_o),  64'(k == d));
        check("ready", 64'(mem_ready_o), 64'(k == d));
        if (k == d) begin
          if (!we) exp_rdata = rd;
          exp_err = (resp != 2'b00);
        end
        check("rdata", 64'(mem_rdata_o), 64'(exp_rdata));
        check("err",   64'(mem_err_o),   64'(exp_err));
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    mem_req_i = 0; mem_we_i = 0; mem_addr_i = 0; mem_wdata_i = 0; mem_wstrb_i = 0;
    m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
    m_axi_bvalid = 0; m_axi_rvalid = 0; m_axi_bresp = 0; m_axi_rresp = 0; m_axi_rdata = 0;
    repeat (2) @(negedge clk);
    check("rst_valids", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready}), 64'(0));
    check("rst_done",   64'(mem_done_o), 64'(0));
    check("rst_err",    64'(mem_err_o), 64'(0));
    check("rst_rdata",  64'(mem_rdata_o), 64'(0));
    check("rst_addr",   64'({m_axi_awaddr, m_axi_araddr}), 64'(0));
    check("rst_wdata",  64'({m_axi_wdata, m_axi_wstrb}), 64'(0));
    check("rst_ready",  64'(mem_ready_o), 64'(1));
    rst_n = 1'b1;
    idle(2);

    // Zero-wait write, skewed write, delayed read
    run_txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 2'b00, 32'h0);
    idle(1);
    run_txn(1'b1, 32'h0000_0020, 32'hCAFE_F00D, 4'h3, 3, 0, 0, 2'b00, 32'h0);
    idle(1);
    run_txn(1'b0, 32'h0800_0004, 32'h0, 4'h0, 0, 0, 2, 2'b00, 32'h1234_5678);
    idle(3);
    // Error response followed by a clean read
    run_txn(1'b1, 32'h0000_0030, 32'h5555_AAAA, 4'h5, 1, 2, 1, 2'b10, 32'h0);
    idle(1);
    run_txn(1'b0, 32'h0000_0034, 32'h0, 4'h0, 1, 0, 0, 2'b00, 32'h8765_4321);
    // Back-to-back: the read is requested in the write's done cycle
    run_txn(1'b1, 32'h0000_0004, 32'h0BAD_CAFE, 4'hF, 0, 0, 0, 2'b00, 32'h0);
    run_txn(1'b0, 32'h0000_0004, 32'h0, 4'h0, 0, 0, 0, 2'b00, 32'h0BAD_CAFE);
    idle(1);

    // Reset while waiting in the read-data phase
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h0000_0100;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_bvalid = 1'b0;
    @(posedge clk); @(negedge clk);
    junk_core(1'b0);
    m_axi_arready = 1'b1;
    check("rst_test_arvalid", 64'(m_axi_arvalid), 64'(1));
    @(posedge clk); @(negedge clk);
    m_axi_arready = 1'b0;
    check("rst_test_rready", 64'(m_axi_rready), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valids", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready}), 64'(0));
    check("midrst_done",   64'(mem_done_o), 64'(0));
    check("midrst_err",    64'(mem_err_o), 64'(0));
    check("midrst_rdata",  64'(mem_rdata_o), 64'(0));
    check("midrst_addr",   64'({m_axi_awaddr, m_axi_araddr}), 64'(0));
    check("midrst_ready",  64'(mem_ready_o), 64'(1));
    exp_rdata = '0;
    exp_err   = 1'b0;
    m_axi_rvalid = 1'b1; m_axi_rresp = 2'b11; m_axi_rdata = 32'hFFFF_0000;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      check("stale_done",   64'(mem_done_o), 64'(0));
      check("stale_rready", 64'(m_axi_rready), 64'(0));
      check("stale_rdata",  64'(mem_rdata_o), 64'(0));
      check("stale_ready",  64'(mem_ready_o), 64'(1));
    end
    m_axi_rvalid = 1'b0;
    run_txn(1'b0, 32'h0000_0200, 32'h0, 4'h0, 1, 0, 1, 2'b00, 32'hA5A5_5A5A);
    idle(1);

    // Randomized transactions, occasionally back-to-back
    for (int t = 0; t < 40; t++) begin
      run_txn(rnd(), $urandom, $urandom, 4'($urandom_range(0, 15)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom);
      if (rnd()) idle(int'($urandom_range(1, 2)));
    end
    idle(1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
